uart_tx_arbiter: RTL and testbench

- Shares the SoC's single UART transmitter between NREQ byte-stream requesters, e.g. the picorv32 UART register path and a debug/boot-message source.
- Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and the UART TX core inside soc_picorv32; clocked from the board clock path.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// Latency: grant 1 cycle after req_valid in IDLE; tx_start/tx_data 1 cycle after a valid/ready transfer.
// Backpressure: req_ready only to the owner, only while tx_busy is low; one byte in flight, no buffering.
module uart_tx_arbiter #(
    parameter int NREQ         = 2,
    parameter int HOLD_TIMEOUT = 1024,
    parameter int ACK_TIMEOUT  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 ack_err
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_owner;
    logic [OW-1:0]   pick;
    logic [OW:0]     rr_idx;
    logic [HW-1:0]   hold_cnt;
    logic [AW-1:0]   ack_cnt;
    logic            last_q;
    logic            own_valid;
    logic [7:0]      own_data;

    assign own_valid = req_valid[owner];
    assign own_data  = req_data[{owner, 3'b000} +: 8];

    // Walk offsets from farthest to nearest so the requester just after last_owner wins.
    always_comb begin
        pick   = last_owner;
        rr_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            rr_idx = {1'b0, last_owner} + (OW+1)'(i);
            if (rr_idx >= (OW+1)'(NREQ))
                rr_idx = rr_idx - (OW+1)'(NREQ);
            if (req_valid[rr_idx[OW-1:0]])
                pick = rr_idx[OW-1:0];
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ISSUE)
            req_ready[owner] = req_valid[owner] & ~tx_busy;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            hold_cnt   <= '0;
            ack_cnt    <= '0;
            last_q     <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner    <= pick;
                        grant    <= NREQ'(1) << pick;
                        hold_cnt <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (own_valid && !tx_busy) begin
                        tx_data  <= own_data;
                        tx_start <= 1'b1;
                        last_q   <= req_last[owner];
                        hold_cnt <= '0;
                        ack_cnt  <= '0;
                        state    <= WAIT_ACK;
                    end else if (!own_valid) begin
                        if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                            last_owner <= owner;
                            grant      <= '0;
                            hold_cnt   <= '0;
                            state      <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        // The UART never acknowledged; flag it and treat the byte as sent.
                        ack_err <= 1'b1;
                        if (last_q) begin
                            last_owner <= owner;
                            grant      <= '0;
                            state      <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            last_owner <= owner;
                            grant      <= '0;
                            state      <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two queue-driven requesters and a simple UART busy model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data  = '0;
    logic [1:0]  req_last  = '0;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        ack_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NREQ(2),
        .HOLD_TIMEOUT(16),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy rises the cycle after tx_start and stays high 10 cycles.
    logic uart_ok = 1'b1;
    int   busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (uart_ok && tx_start)
            busy_cnt <= 10;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    // Requester sources: entries are {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] src_en = '0;
    logic [1:0] acc = '0;
    always @(posedge clk) acc <= req_valid & req_ready;

    always @(negedge clk) begin
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        if (src_en[0] && q0.size() > 0) begin
            req_valid[0]   = 1'b1;
            req_data[7:0]  = q0[0][7:0];
            req_last[0]    = q0[0][8];
        end else begin
            req_valid[0]   = 1'b0;
            req_data[7:0]  = '0;
            req_last[0]    = 1'b0;
        end
        if (src_en[1] && q1.size() > 0) begin
            req_valid[1]   = 1'b1;
            req_data[15:8] = q1[0][7:0];
            req_last[1]    = q1[0][8];
        end else begin
            req_valid[1]   = 1'b0;
            req_data[15:8] = '0;
            req_last[1]    = 1'b0;
        end
    end

    // Output logs, sampled mid-cycle.
    logic [7:0] tx_dat_log[$];
    int         tx_cyc_log[$];
    logic [1:0] grant_log[$];
    int         grant_cyc_log[$];
    logic [1:0] prev_grant = '0;
    int         ack_rise_cyc = -1;
    int         lock_viol = 0;

    always @(negedge clk) begin
        if (tx_start) begin
            tx_dat_log.push_back(tx_data);
            tx_cyc_log.push_back(cyc);
        end
        if (grant !== prev_grant) begin
            grant_log.push_back(grant);
            grant_cyc_log.push_back(cyc);
            prev_grant = grant;
        end
        if (ack_err === 1'b1 && ack_rise_cyc < 0)
            ack_rise_cyc = cyc;
        if ((req_ready & ~grant) != 2'b00)
            lock_viol++;
    end

    task automatic clear_logs();
        tx_dat_log.delete();
        tx_cyc_log.delete();
        grant_log.delete();
        grant_cyc_log.delete();
        ack_rise_cyc = -1;
        lock_viol    = 0;
    endtask

    task automatic reset_begin();
        src_en = '0;
        repeat (15) @(posedge clk);
        #1;
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic reset_end();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int k = 0; k < budget && tx_dat_log.size() < n; k++)
            @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_d[3] = '{8'h41, 8'h42, 8'h43};
        logic [7:0] got;
        logic [1:0] gg;
        int         c_rel, c_last;
        reset_begin();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        src_en = 2'b01;
        reset_end();
        wait_tx(3, 200);
        repeat (20) @(negedge clk);
        total++; if (tx_dat_log.size() !== 3) begin bad++; $display("FAIL single_count: got %0d want 3", tx_dat_log.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < tx_dat_log.size()) ? tx_dat_log[i] : 8'hxx;
            total++; if (got !== exp_d[i]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp_d[i]); end
        end
        total++; if (grant_log.size() !== 2) begin bad++; $display("FAIL single_grant_changes: got %0d want 2", grant_log.size()); end
        gg = (grant_log.size() > 0) ? grant_log[0] : 2'bxx;
        total++; if (gg !== 2'b01) begin bad++; $display("FAIL single_grant0: got %b want 01", gg); end
        gg = (grant_log.size() > 1) ? grant_log[1] : 2'bxx;
        total++; if (gg !== 2'b00) begin bad++; $display("FAIL single_grant1: got %b want 00", gg); end
        c_rel  = (grant_cyc_log.size() > 1) ? grant_cyc_log[1] : -1;
        c_last = (tx_cyc_log.size() > 2) ? tx_cyc_log[2] : 1 << 30;
        total++; if (!(c_rel > c_last)) begin bad++; $display("FAIL single_grant_held: release cycle %0d not after last start %0d", c_rel, c_last); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL single_ack_err: got %b want 0", ack_err); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d[4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        logic [1:0] exp_g[7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        logic [7:0] got;
        logic [1:0] gg;
        reset_begin();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'hA0 + 8'(i)});
            q1.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        src_en = 2'b11;
        reset_end();
        wait_tx(4, 300);
        total++; if (tx_dat_log.size() < 4) begin bad++; $display("FAIL rr_count: got %0d want >=4", tx_dat_log.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < tx_dat_log.size()) ? tx_dat_log[i] : 8'hxx;
            total++; if (got !== exp_d[i]) begin bad++; $display("FAIL rr_byte%0d: got %h want %h", i, got, exp_d[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            gg = (i < grant_log.size()) ? grant_log[i] : 2'bxx;
            total++; if (gg !== exp_g[i]) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", i, gg, exp_g[i]); end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp_d[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
        logic [1:0] exp_g[3] = '{2'b01, 2'b00, 2'b10};
        logic [7:0] got;
        logic [1:0] gg;
        reset_begin();
        q0.push_back({1'b0, 8'h10});
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h12});
        q0.push_back({1'b1, 8'h13});
        q1.push_back({1'b1, 8'h20});
        src_en = 2'b01;
        reset_end();
        wait_tx(1, 100);
        @(posedge clk);
        #1;
        src_en = 2'b11;
        wait_tx(5, 400);
        total++; if (tx_dat_log.size() !== 5) begin bad++; $display("FAIL lock_count: got %0d want 5", tx_dat_log.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < tx_dat_log.size()) ? tx_dat_log[i] : 8'hxx;
            total++; if (got !== exp_d[i]) begin bad++; $display("FAIL lock_byte%0d: got %h want %h", i, got, exp_d[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            gg = (i < grant_log.size()) ? grant_log[i] : 2'bxx;
            total++; if (gg !== exp_g[i]) begin bad++; $display("FAIL lock_grant%0d: got %b want %b", i, gg, exp_g[i]); end
        end
        total++; if (lock_viol !== 0) begin bad++; $display("FAIL lock_ready_nonowner: got %0d cycles want 0", lock_viol); end
    endtask

    // Stall counting starts when the owner is back in ISSUE: start T, busy T+1..T+10,
    // ISSUE from T+12, 16 idle cycles, grant 00 at T+28 and 10 at T+29.
    task automatic test_hold_timeout();
        logic [7:0] got;
        logic [1:0] gg;
        int         t0, c;
        reset_begin();
        q0.push_back({1'b0, 8'h61});
        q1.push_back({1'b1, 8'h71});
        src_en = 2'b11;
        reset_end();
        wait_tx(2, 300);
        repeat (30) @(negedge clk);
        total++; if (tx_dat_log.size() !== 2) begin bad++; $display("FAIL hold_count: got %0d want 2", tx_dat_log.size()); end
        got = (tx_dat_log.size() > 0) ? tx_dat_log[0] : 8'hxx;
        total++; if (got !== 8'h61) begin bad++; $display("FAIL hold_byte0: got %h want 61", got); end
        got = (tx_dat_log.size() > 1) ? tx_dat_log[1] : 8'hxx;
        total++; if (got !== 8'h71) begin bad++; $display("FAIL hold_byte1: got %h want 71", got); end
        t0 = (tx_cyc_log.size() > 0) ? tx_cyc_log[0] : -1000;
        gg = (grant_log.size() > 1) ? grant_log[1] : 2'bxx;
        total++; if (gg !== 2'b00) begin bad++; $display("FAIL hold_grant_drop: got %b want 00", gg); end
        c = (grant_cyc_log.size() > 1) ? grant_cyc_log[1] : -1;
        total++; if (c !== t0 + 28) begin bad++; $display("FAIL hold_drop_cycle: got %0d want %0d", c, t0 + 28); end
        gg = (grant_log.size() > 2) ? grant_log[2] : 2'bxx;
        total++; if (gg !== 2'b10) begin bad++; $display("FAIL hold_grant_next: got %b want 10", gg); end
        c = (grant_cyc_log.size() > 2) ? grant_cyc_log[2] : -1;
        total++; if (c !== t0 + 29) begin bad++; $display("FAIL hold_next_cycle: got %0d want %0d", c, t0 + 29); end
    endtask

    task automatic test_ack_timeout();
        logic [7:0] got;
        int         t0, c;
        reset_begin();
        uart_ok = 1'b0;
        q0.push_back({1'b0, 8'h50});
        q0.push_back({1'b1, 8'h51});
        src_en = 2'b01;
        reset_end();
        wait_tx(2, 100);
        repeat (10) @(negedge clk);
        total++; if (tx_dat_log.size() !== 2) begin bad++; $display("FAIL ack_count: got %0d want 2", tx_dat_log.size()); end
        t0 = (tx_cyc_log.size() > 0) ? tx_cyc_log[0] : -1000;
        total++; if (ack_rise_cyc !== t0 + 4) begin bad++; $display("FAIL ack_err_cycle: got %0d want %0d", ack_rise_cyc, t0 + 4); end
        c = (tx_cyc_log.size() > 1) ? tx_cyc_log[1] : -1;
        total++; if (c !== t0 + 5) begin bad++; $display("FAIL ack_next_start: got %0d want %0d", c, t0 + 5); end
        got = (tx_dat_log.size() > 1) ? tx_dat_log[1] : 8'hxx;
        total++; if (got !== 8'h51) begin bad++; $display("FAIL ack_next_byte: got %h want 51", got); end
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL ack_err_sticky: got %b want 1", ack_err); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL ack_release: got %b want 00", grant); end
        uart_ok = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] got;
        logic [1:0] gg;
        reset_begin();
        q0.push_back({1'b0, 8'h81});
        q0.push_back({1'b1, 8'h82});
        q1.push_back({1'b1, 8'h91});
        src_en = 2'b11;
        reset_end();
        wait_tx(1, 100);
        repeat (4) @(negedge clk);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL mid_pre_grant: got %b want 01", grant); end
        #2;
        resetn = 1'b0;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL mid_async_grant: got %b want 00", grant); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_async_tx_start: got %b want 0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_async_tx_data: got %h want 00", tx_data); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL mid_async_ready: got %b want 00", req_ready); end
        @(negedge clk);
        @(posedge clk);
        #1;
        clear_logs();
        @(negedge clk);
        resetn = 1'b1;
        wait_tx(2, 200);
        gg = (grant_log.size() > 0) ? grant_log[0] : 2'bxx;
        total++; if (gg !== 2'b01) begin bad++; $display("FAIL mid_first_grant: got %b want 01", gg); end
        got = (tx_dat_log.size() > 0) ? tx_dat_log[0] : 8'hxx;
        total++; if (got !== 8'h82) begin bad++; $display("FAIL mid_byte0: got %h want 82", got); end
        got = (tx_dat_log.size() > 1) ? tx_dat_log[1] : 8'hxx;
        total++; if (got !== 8'h91) begin bad++; $display("FAIL mid_byte1: got %h want 91", got); end
    endtask

    initial begin
        resetn = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_packet_lock();
        test_hold_timeout();
        test_ack_timeout();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
